// File: rtl/connect4_pkg.sv
// Shared board dimensions, result encodings and sequencer state encoding
// for the Connect-4 move path.
package connect4_pkg;

    localparam int unsigned DEF_COLS = 7;
    localparam int unsigned DEF_ROWS = 6;

    typedef enum logic [1:0] {
        NEXT_TURN  = 2'b00,
        PLAYER_WIN = 2'b01,
        TIE_GAME   = 2'b10
    } game_status_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_REPORT = 3'd3,
        ST_LOCKED = 3'd4
    } seq_state_e;

    // A win on the last cell outranks the tie.
    function automatic game_status_e resolve_status(input logic win, input logic board_full);
        if (win) begin
            return PLAYER_WIN;
        end else if (board_full) begin
            return TIE_GAME;
        end
        return NEXT_TURN;
    endfunction

endpackage

// File: rtl/drop_sequencer_if.sv
// Move-request, board-write and win-checker handshake bundle of drop_sequencer.
interface drop_sequencer_if;

    logic       drop_req;
    logic [2:0] drop_col;
    logic       player;
    logic       win_done;
    logic       win_found;

    logic       busy;
    logic       invalid_column;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic       wr_player;
    logic       check_start;
    logic       status_valid;
    logic [1:0] game_status;
    logic [5:0] moves;

    modport master (
        output drop_req, drop_col, player, win_done, win_found,
        input  busy, invalid_column, wr_en, wr_row, wr_col, wr_player,
               check_start, status_valid, game_status, moves
    );

    modport slave (
        input  drop_req, drop_col, player, win_done, win_found,
        output busy, invalid_column, wr_en, wr_row, wr_col, wr_player,
               check_start, status_valid, game_status, moves
    );

endinterface

// File: rtl/col_height_bank.sv
// Per-column fill heights: read mux with full flag, single-column increment
// saturating at ROWS. Heights are 3 bits wide, so ROWS must not exceed 7.
module col_height_bank
    import connect4_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rd_col,
    output logic [2:0] rd_height,
    output logic       rd_full,
    input  logic       inc_en,
    input  logic [2:0] inc_col
);

    logic [2:0] height_q [COLS];
    logic [2:0] height_d [COLS];

    // Columns beyond the board read as full so they are rejected like a full column.
    always_comb begin
        rd_height = '0;
        rd_full   = 1'b1;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (32'(rd_col) == i) begin
                rd_height = height_q[i];
                rd_full   = (32'(height_q[i]) >= ROWS);
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < COLS; i++) begin
            height_d[i] = height_q[i];
            if (inc_en && (32'(inc_col) == i) && (32'(height_q[i]) < ROWS)) begin
                height_d[i] = height_q[i] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                height_q[i] <= '0;
            end
        end else begin
            height_q <= height_d;
        end
    end

endmodule

// File: rtl/drop_sequencer.sv
// Connect-4 move sequencer: validates a drop, writes the piece, launches the
// win check and reports the move result; locks after a win or a full board.
module drop_sequencer
    import connect4_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input logic             clk,
    input logic             reset,
    drop_sequencer_if.slave bus
);

    localparam int unsigned CELLS = COLS * ROWS;

    seq_state_e   state_q, state_d;
    logic         invalid_q, invalid_d;
    logic         wr_en_q, wr_en_d;
    logic [2:0]   wr_row_q, wr_row_d;
    logic [2:0]   wr_col_q, wr_col_d;
    logic         wr_player_q, wr_player_d;
    logic         check_start_q, check_start_d;
    logic         status_valid_q, status_valid_d;
    game_status_e game_status_q, game_status_d;
    logic [5:0]   moves_q, moves_d;

    logic [2:0]   rd_height;
    logic         rd_full;
    logic         inc_en;

    // wr_col_q doubles as the latched column for the height increment.
    assign inc_en = (state_q == ST_WRITE);

    col_height_bank #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_heights (
        .clk       (clk),
        .reset     (reset),
        .rd_col    (bus.drop_col),
        .rd_height (rd_height),
        .rd_full   (rd_full),
        .inc_en    (inc_en),
        .inc_col   (wr_col_q)
    );

    always_comb begin
        state_d        = state_q;
        invalid_d      = 1'b0;
        wr_en_d        = 1'b0;
        wr_row_d       = wr_row_q;
        wr_col_d       = wr_col_q;
        wr_player_d    = wr_player_q;
        check_start_d  = 1'b0;
        status_valid_d = 1'b0;
        game_status_d  = game_status_q;
        moves_d        = moves_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.drop_req) begin
                    if (rd_full) begin
                        invalid_d = 1'b1;
                    end else begin
                        state_d     = ST_WRITE;
                        wr_en_d     = 1'b1;
                        wr_row_d    = rd_height;
                        wr_col_d    = bus.drop_col;
                        wr_player_d = bus.player;
                    end
                end
            end
            ST_WRITE: begin
                state_d       = ST_CHECK;
                check_start_d = 1'b1;
                if (32'(moves_q) < CELLS) begin
                    moves_d = moves_q + 6'd1;
                end
            end
            ST_CHECK: begin
                if (bus.win_done) begin
                    state_d        = ST_REPORT;
                    status_valid_d = 1'b1;
                    game_status_d  = resolve_status(bus.win_found, 32'(moves_q) == CELLS);
                end
            end
            ST_REPORT: begin
                state_d = (game_status_q == NEXT_TURN) ? ST_IDLE : ST_LOCKED;
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            invalid_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_row_q       <= '0;
            wr_col_q       <= '0;
            wr_player_q    <= 1'b0;
            check_start_q  <= 1'b0;
            status_valid_q <= 1'b0;
            game_status_q  <= NEXT_TURN;
            moves_q        <= '0;
        end else begin
            state_q        <= state_d;
            invalid_q      <= invalid_d;
            wr_en_q        <= wr_en_d;
            wr_row_q       <= wr_row_d;
            wr_col_q       <= wr_col_d;
            wr_player_q    <= wr_player_d;
            check_start_q  <= check_start_d;
            status_valid_q <= status_valid_d;
            game_status_q  <= game_status_d;
            moves_q        <= moves_d;
        end
    end

    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.invalid_column = invalid_q;
    assign bus.wr_en          = wr_en_q;
    assign bus.wr_row         = wr_row_q;
    assign bus.wr_col         = wr_col_q;
    assign bus.wr_player      = wr_player_q;
    assign bus.check_start    = check_start_q;
    assign bus.status_valid   = status_valid_q;
    assign bus.game_status    = game_status_q;
    assign bus.moves          = moves_q;

endmodule
